ovl_always_multi: RTL and testbench

- Multi-channel, parametrised successor to the single-bit "always" checker.
- Monitors WIDTH independent test_expr bits every clock. Flags a channel once it has been false for FAIL_LIMIT consecutive enabled samples.
- Tracks a saturating violation count and latches the first failing channel.
- Sits beside the design under check as a synthesizable monitor, supporting both simulation and emulation.

---
 rtl/ovl_always_multi_if.sv | 28 ++
 rtl/ovl_always_multi.sv | 143 ++++++++++++++
 tb/tb_ovl_always_multi.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ovl_always_multi_if.sv
// Bundle between a checker and its environment: the environment drives the sampled
// property bits and qualifiers; the checker returns fire flags, the count and the capture.
interface ovl_always_multi_if #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8,
    parameter int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
    // No valid/ready: every rising clk is a sample, qualified only by enable.
    logic                 enable;
    logic                 clear;
    logic [WIDTH-1:0]     test_expr;
    logic [2:0]           fire;
    logic [WIDTH-1:0]     fire_chan;
    logic [CNT_WIDTH-1:0] viol_count;
    logic [IDX_W-1:0]     first_fail_idx;
    logic                 first_fail_valid;
    logic                 state_dbg;

    modport master (
        output enable, clear, test_expr,
        input  fire, fire_chan, viol_count, first_fail_idx, first_fail_valid, state_dbg
    );

    modport slave (
        input  enable, clear, test_expr,
        output fire, fire_chan, viol_count, first_fail_idx, first_fail_valid, state_dbg
    );
endinterface

// File: rtl/ovl_always_multi.sv
// Multi-channel "always" checker: flags each channel after FAIL_LIMIT consecutive enabled
// false samples, counts violating cycles and latches the first failing channel.
module ovl_always_multi #(
    parameter int WIDTH         = 4,
    parameter int PROPERTY_TYPE = 0,
    parameter int FAIL_LIMIT    = 1,
    parameter int CNT_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int XZ_CHECK      = 1
) (
    input logic               clk,
    input logic               reset,
    ovl_always_multi_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RUN_W = $clog2(FAIL_LIMIT + 1);
    localparam logic [RUN_W-1:0]     LIMIT    = RUN_W'(FAIL_LIMIT);
    localparam logic [3:0]           SET_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam bit                   ACTIVE   = (PROPERTY_TYPE != 2);

    generate
        if (PROPERTY_TYPE < 0 || PROPERTY_TYPE > 2) begin : g_bad_type
            $error("ovl_always_multi: PROPERTY_TYPE must be 0, 1 or 2");
        end
        if (WIDTH < 1 || WIDTH > 32 || FAIL_LIMIT < 1 || FAIL_LIMIT > 255
            || SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_range
            $error("ovl_always_multi: parameter out of range");
        end
    endgenerate

    typedef enum logic {SETTLE = 1'b0, ARMED = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic       armed_seen_q;
    logic       fire2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= (SETTLE_CYCLES == 0) ? ARMED : SETTLE;
            settle_q     <= '0;
            armed_seen_q <= 1'b0;
            fire2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            armed_seen_q <= armed_seen_q | (state_q == ARMED);
            fire2_q      <= (state_q == ARMED) && !armed_seen_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (state_q == SETTLE) begin
            settle_d = settle_q + 4'd1;
            if (settle_q == SET_LAST) state_d = ARMED;
        end
    end

    logic                        sample_en;
    logic [WIDTH-1:0]            xz_bits;
    logic [WIDTH-1:0][RUN_W-1:0] run_q, run_d;
    logic [WIDTH-1:0]            fire_chan_q, fire_chan_d;
    logic                        fire0_q, fire1_q;
    logic [CNT_WIDTH-1:0]        viol_q;
    logic [IDX_W-1:0]            idx_q, low_idx;
    logic                        valid_q;

    assign sample_en = (state_q == ARMED) && bus.enable;

    // Unknown bits are only observable in a 4-state simulator.
    always_comb begin
        xz_bits = '0;
`ifndef SYNTHESIS
        if (XZ_CHECK != 0) begin
            for (int i = 0; i < WIDTH; i++) xz_bits[i] = $isunknown(bus.test_expr[i]);
        end
`endif
    end

    always_comb begin
        run_d       = run_q;
        fire_chan_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sample_en && !xz_bits[i]) begin
                if (bus.test_expr[i]) begin
                    run_d[i] = '0;
                end else begin
                    if (run_q[i] != LIMIT) run_d[i] = run_q[i] + RUN_W'(1);
                    fire_chan_d[i] = (run_d[i] == LIMIT);
                end
            end
        end
        if (bus.clear) begin
            run_d       = '0;
            fire_chan_d = '0;
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (fire_chan_q[i]) low_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q       <= '0;
            fire_chan_q <= '0;
            fire0_q     <= 1'b0;
            fire1_q     <= 1'b0;
            viol_q      <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            run_q       <= run_d;
            fire_chan_q <= fire_chan_d;
            fire0_q     <= |fire_chan_d;
            fire1_q     <= sample_en && (|xz_bits);
            if (bus.clear) begin
                viol_q  <= '0;
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                if (fire0_q && viol_q != CNT_MAX) viol_q <= viol_q + CNT_WIDTH'(1);
                if (fire0_q && !valid_q) begin
                    idx_q   <= low_idx;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.fire             = ACTIVE ? {fire2_q, fire1_q, fire0_q} : 3'b000;
    assign bus.fire_chan        = ACTIVE ? fire_chan_q : '0;
    assign bus.viol_count       = ACTIVE ? viol_q : '0;
    assign bus.first_fail_idx   = ACTIVE ? idx_q : '0;
    assign bus.first_fail_valid = ACTIVE ? valid_q : 1'b0;
    assign bus.state_dbg        = logic'(state_q);
endmodule

// File: tb/tb_ovl_always_multi.sv
// Directed plus random bench for ovl_always_multi against a counting reference model.
module tb_ovl_always_multi;
    localparam int W     = 4;
    localparam int LIM   = 3;
    localparam int CW    = 3;
    localparam int SETTLE = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ovl_always_multi_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    ovl_always_multi #(
        .WIDTH(W), .PROPERTY_TYPE(0), .FAIL_LIMIT(LIM),
        .CNT_WIDTH(CW), .SETTLE_CYCLES(SETTLE), .XZ_CHECK(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Reference model: edges since release, unbounded false-run lengths per channel.
    int         edges;
    int         fails[W];
    logic [W-1:0] m_chan;
    logic       m_f0, m_f1, m_f2;
    int         m_cnt, m_idx;
    logic       m_valid;

    task automatic model_reset();
        edges = 0;
        for (int i = 0; i < W; i++) fails[i] = 0;
        m_chan = '0; m_f0 = 0; m_f1 = 0; m_f2 = 0;
        m_cnt = 0; m_idx = 0; m_valid = 0;
    endtask

    task automatic model_edge(input logic en, input logic clr, input logic [W-1:0] te);
        logic checked;
        logic any_x;
        edges++;
        checked = (edges > SETTLE) && en;
        m_f2 = (edges == SETTLE + 1);
        if (clr) begin
            m_cnt = 0; m_valid = 0; m_idx = 0;
        end else begin
            if (m_f0 && m_cnt < CMAX) m_cnt++;
            if (m_f0 && !m_valid) begin
                m_valid = 1;
                for (int i = W - 1; i >= 0; i--) if (m_chan[i]) m_idx = i;
            end
        end
        any_x = 0;
        for (int i = 0; i < W; i++) begin
            m_chan[i] = 0;
            if (clr) fails[i] = 0;
            else if (checked && $isunknown(te[i])) any_x = 1;
            else if (checked) begin
                if (te[i] === 1'b1) fails[i] = 0;
                else fails[i]++;
                m_chan[i] = (te[i] === 1'b0) && (fails[i] >= LIM);
            end
        end
        m_f1 = checked && any_x;
        m_f0 = |m_chan;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".fire"}, 32'(bus.fire), 32'({m_f2, m_f1, m_f0}));
        check({tag, ".fire_chan"}, 32'(bus.fire_chan), 32'(m_chan));
        check({tag, ".viol_count"}, 32'(bus.viol_count), 32'(m_cnt));
        check({tag, ".first_fail_idx"}, 32'(bus.first_fail_idx), 32'(m_idx));
        check({tag, ".first_fail_valid"}, 32'(bus.first_fail_valid), 32'(m_valid));
        check({tag, ".state"}, 32'(bus.state_dbg), 32'(edges >= SETTLE));
    endtask

    task automatic step(input logic en, input logic clr, input logic [W-1:0] te, input string tag);
        bus.enable = en;
        bus.clear = clr;
        bus.test_expr = te;
        @(posedge clk);
        model_edge(en, clr, te);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        check_all({tag, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] te;
        bus.enable = 1'b1;
        bus.clear = 1'b0;
        bus.test_expr = '1;
        model_reset();
        @(negedge clk);
        do_reset("reset0");

        for (int k = 0; k < 5; k++) step(1, 0, 4'b1111, "settle");
        for (int k = 0; k < 5; k++) step(1, 0, 4'b1011, "ch2_low");
        for (int k = 0; k < 3; k++) step(1, 0, 4'b1111, "ch2_recover");

        step(1, 1, 4'b1111, "clear1");
        for (int k = 0; k < 4; k++) step(1, 0, 4'b0101, "ch1_ch3_low");
        for (int k = 0; k < 4; k++) step(1, 0, 4'b1110, "ch0_later");
        step(1, 0, 4'b1111, "ch0_recover");

        step(1, 0, 4'b1110, "gap_f1");
        step(1, 0, 4'b1110, "gap_f2");
        for (int k = 0; k < 3; k++) step(0, 0, 4'b1110, "gap_disabled");
        step(1, 0, 4'b1110, "gap_f3");
        step(1, 0, 4'b1111, "gap_recover");

        for (int k = 0; k < 12; k++) step(1, 0, 4'b1110, "saturate");
        step(1, 0, 4'b1111, "sat_recover");
        step(1, 0, 4'b1111, "sat_hold");

        step(1, 1, 4'b1111, "clear2");
        step(1, 0, 4'b0111, "pre_f1");
        step(1, 0, 4'b0111, "pre_f2");
        step(1, 1, 4'b0111, "clear_on_fire");
        step(1, 0, 4'b0111, "after_clear");

        te = 4'b1x11;
        step(1, 0, te, "xz_sample");
        step(1, 0, 4'b1111, "xz_after");

        for (int k = 0; k < 80; k++) begin
            for (int i = 0; i < W; i++) te[i] = ($urandom_range(0, 9) >= 5);
            step($urandom_range(0, 7) != 0, $urandom_range(0, 29) == 0, te, "random");
        end

        for (int k = 0; k < 3; k++) step(1, 0, 4'b1101, "pre_reset");
        do_reset("reset_mid");
        for (int k = 0; k < 8; k++) step(1, 0, 4'b1101, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
